data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory-side responder for the CPU data-memory interface. Accepts single-word read or byte-lane-masked write requests from the memory controller, holds them for a programmable number of wait states, commits them to an internal word-organised array, and returns a one-cycle `Ready` pulse with read data held stable until the next read completes. It sits between the memory controller's `ReadEnable`/`WriteEnable`/`DataToMem` outputs and its `DataFromMem`/ready inputs, and models a slow synchronous data RAM.

## Interface
- `ADDR_WIDTH`, 10: word-address bits; array depth is 2^ADDR_WIDTH 32-bit words.
- `WAIT_CYCLES`, 2: wait states between request acceptance and commit (0–15).

- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `Address` in 32: byte address; word index = `Address[ADDR_WIDTH+1:2]`; bits [1:0] and above ADDR_WIDTH+1 are ignored.
- `DataIn` in 32: write data, already lane-replicated by the controller.
- `ReadEnable` in 1: read request.
- `WriteEnable` in 4: per-byte write enables; bit 3 = `DataIn[31:24]`, bit 0 = `DataIn[7:0]`.
- `DataOut` out 32: read data (registered).
- `Ready` out 1: completion pulse, high for exactly one cycle per request.
- `Busy` out 1: high while a request is in flight (state != IDLE).

## Operation
- States: IDLE, WAIT, DONE.
- IDLE: request = `ReadEnable | (|WriteEnable)`. On a clock edge with a request present, latch word index, `DataIn`, `WriteEnable`, and op type (write if any WE bit is set, else read). Load the counter with `WAIT_CYCLES`. Go to WAIT, or commit immediately and go to DONE if `WAIT_CYCLES==0`.
- WAIT: decrement the counter each edge. On the edge where the counter is 1, commit and go to DONE.
- Commit, write: for each set latched WE bit i, `mem[idx][8i+7:8i] <= DataIn[8i+7:8i]`. Clear lanes are untouched. `DataOut` is unchanged.
- Commit, read: `DataOut <= mem[idx]` as a full word. Sub-word extraction and sign extension belong to the controller.
- DONE: `Ready=1` for one cycle, then go to IDLE unconditionally.
- Input changes during WAIT or DONE are ignored. Only latched values are used.
- Read and write asserted together: treated as a write. `DataOut` is not updated.
- The controller drops its request the cycle after `Ready`. A request still present in IDLE after DONE is accepted as a new request, which is correct protocol behaviour for back-to-back accesses.

## Timing
- Request present in cycle 0 (IDLE). Commit happens at the edge ending cycle `WAIT_CYCLES`. `Ready` is high in cycle `WAIT_CYCLES+1`.
- Throughput: one request per `WAIT_CYCLES+2` cycles.
- `DataOut` is valid from the `Ready` cycle. It holds until the next read commit, so it stays valid in the cycle after `Ready`, when the controller's stall drops and the pipeline captures the data.
- `Busy` is high from cycle 1 through the `Ready` cycle inclusive.
- Reset (asynchronous, any time): state=IDLE, counter=0, `Ready=0`, `Busy=0`, `DataOut=32'h0`. Array contents are not reset.
- Reset mid-WAIT aborts the request with no commit; memory and `DataOut` are unaltered except `DataOut` clearing to 0. Reset during DONE after a write leaves the write in place.
- Address wrap: indices alias modulo 2^ADDR_WIDTH words. There is no error response.

## Test plan
- Word write then read, `WAIT_CYCLES=2`. Write `0xDEADBEEF` to `Address=0x10` with `WE=1111`. Required: `Ready` high only in cycle 3, `Busy` high in cycles 1–3. Then read `0x10`: `DataOut=0xDEADBEEF` in the `Ready` cycle and the cycle after.
- Byte and half lanes. Starting from `0xDEADBEEF` at `0x10`, write `DataIn=0x55555555` with `WE=0100` -> read returns `0xDE55BEEF`. Then write `DataIn=0xAAAAAAAA` with `WE=0011` -> read returns `0xDE55AAAA`.
- Simultaneous read and write. `ReadEnable=1` with `WE=1111`, `DataIn=0x01234567` at `0x20`, prior `DataOut=0xDE55AAAA`. Required: `DataOut` stays `0xDE55AAAA`, one `Ready` pulse, and a later read of `0x20` returns `0x01234567`.
- Reset mid-operation. Start a write of `0x12345678` to `0x30`, which previously held `0xCAFEF00D`, and assert `rst` in cycle 1. Required: `Ready` never pulses, outputs are at reset values immediately, and a later read of `0x30` returns `0xCAFEF00D`.
- Zero wait and back-to-back. With `WAIT_CYCLES=0`, hold `ReadEnable` for 4 cycles on `0x10`. Required: `Ready` in cycles 1 and 3, with no gaps or doubles.
- Alias and ignored inputs. Write `0x0BADF00D` to `Address=0x1010` with `ADDR_WIDTH=10` -> read of `0x10` returns `0x0BADF00D`. Toggling `Address`/`DataIn` during WAIT does not change the committed result.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Slow synchronous data RAM seen by the CPU memory controller. A single-word
//   read or byte-lane-masked write is accepted in IDLE, held for WAIT_CYCLES
//   wait states, committed to a word-organised array, and acknowledged with a
//   one-cycle Ready pulse. Read data stays registered until the next read
//   commit.
//
// Parameters
//   ADDR_WIDTH  : word-address bits (array depth 2**ADDR_WIDTH x 32 bits)
//   WAIT_CYCLES : wait states between acceptance and commit (0..15)
// Ports
//   clk         : clock, rising edge
//   rst         : asynchronous active-high reset
//   Address     : byte address, word index = Address[ADDR_WIDTH+1:2]
//   DataIn      : lane-replicated write data
//   ReadEnable  : read request
//   WriteEnable : per-byte write enables (bit i -> DataIn[8i+7:8i])
//   DataOut     : registered read data
//   Ready       : one-cycle completion pulse per request
//   Busy        : request in flight (state != IDLE)
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  input  logic        ReadEnable,
  input  logic [3:0]  WriteEnable,
  output logic [31:0] DataOut,
  output logic        Ready,
  output logic        Busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [3:0]              cnt_reg, cnt_next;
  logic [ADDR_WIDTH-1:0]   idx_reg, idx_next;
  logic [31:0]             data_reg, data_next;
  logic [3:0]              we_reg, we_next;
  logic                    is_write_reg, is_write_next;
  logic [31:0]             dout_reg;

  logic [31:0]             mem [DEPTH];

  logic                    req;
  logic                    commit;
  logic [ADDR_WIDTH-1:0]   in_idx;
  logic [ADDR_WIDTH-1:0]   commit_idx;
  logic [31:0]             commit_data;
  logic [3:0]              commit_we;
  logic                    commit_is_write;
  logic                    do_commit;
  logic [3:0]              lane_en;
  logic                    unused_addr;

  assign in_idx      = Address[ADDR_WIDTH+1:2];
  assign unused_addr = ^{Address[31:ADDR_WIDTH+2], Address[1:0]};
  assign req         = ReadEnable | (|WriteEnable);

  // With zero wait states the commit happens on the accepting edge, before
  // anything is latched, so the commit path takes the live inputs in IDLE.
  assign commit_idx      = (state_reg == IDLE) ? in_idx        : idx_reg;
  assign commit_data     = (state_reg == IDLE) ? DataIn        : data_reg;
  assign commit_we       = (state_reg == IDLE) ? WriteEnable   : we_reg;
  assign commit_is_write = (state_reg == IDLE) ? (|WriteEnable) : is_write_reg;

  // An edge that lands while reset is held must never touch the array.
  assign do_commit = commit & ~rst;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    idx_next      = idx_reg;
    data_next     = data_reg;
    we_next       = we_reg;
    is_write_next = is_write_reg;
    commit        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          idx_next      = in_idx;
          data_next     = DataIn;
          we_next       = WriteEnable;
          is_write_next = |WriteEnable;
          cnt_next      = WAIT_LOAD;
          if (WAIT_CYCLES == 0) begin
            commit     = 1'b1;
            state_next = DONE;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          commit     = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      idx_reg      <= '0;
      data_reg     <= 32'h0;
      we_reg       <= 4'h0;
      is_write_reg <= 1'b0;
      dout_reg     <= 32'h0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      idx_reg      <= idx_next;
      data_reg     <= data_next;
      we_reg       <= we_next;
      is_write_reg <= is_write_next;
      // A request with any write lane set is a write, even if ReadEnable is
      // also high, so DataOut only moves on pure reads.
      if (commit && !commit_is_write) begin
        dout_reg <= mem[commit_idx];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane_en
      assign lane_en[gi] = do_commit & commit_we[gi];
    end
  endgenerate

  // Array has no reset; only enabled lanes of the addressed word change.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) begin
        mem[commit_idx][8*i +: 8] <= commit_data[8*i +: 8];
      end
    end
  end

  assign DataOut = dout_reg;
  assign Ready   = (state_reg == DONE);
  assign Busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int W = 2;

  logic        clk;
  logic        rst;
  logic [31:0] a_addr, a_din, a_dout;
  logic        a_re, a_ready, a_busy;
  logic [3:0]  a_we;
  logic [31:0] z_addr, z_din, z_dout;
  logic        z_re, z_ready, z_busy;
  logic [3:0]  z_we;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: word array indexed by the 10-bit word address, plus the
  // value DataOut should be showing.
  logic [31:0] mem_m [0:1023];
  logic [31:0] mdout;
  logic [31:0] mdout0;

  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst(rst), .Address(a_addr), .DataIn(a_din),
    .ReadEnable(a_re), .WriteEnable(a_we),
    .DataOut(a_dout), .Ready(a_ready), .Busy(a_busy)
  );

  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .Address(z_addr), .DataIn(z_din),
    .ReadEnable(z_re), .WriteEnable(z_we),
    .DataOut(z_dout), .Ready(z_ready), .Busy(z_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One complete request on the WAIT_CYCLES=2 instance. The model is updated
  // from the architectural rules first, then the cycle-by-cycle handshake is
  // checked. Request is held until the Ready cycle, dropped afterwards.
  task automatic run_op(input logic [31:0] addr, input logic [31:0] din,
                        input logic re, input logic [3:0] we, input bit scramble);
    logic [9:0] idx;
    idx = addr[11:2];
    if (we != 4'h0) begin
      for (int l = 0; l < 4; l++)
        if (we[l]) mem_m[idx][8*l +: 8] = din[8*l +: 8];
    end else begin
      mdout = mem_m[idx];
    end
    @(negedge clk);
    a_addr = addr; a_din = din; a_re = re; a_we = we;
    chk("busy_c0", {31'h0, a_busy}, 32'h0);
    for (int c = 1; c <= W + 1; c++) begin
      @(negedge clk);
      chk($sformatf("busy_c%0d", c), {31'h0, a_busy}, 32'h1);
      chk($sformatf("ready_c%0d", c), {31'h0, a_ready}, {31'h0, (c == W + 1)});
      if (c == W + 1) begin
        chk("dout_ready", a_dout, mdout);
        a_re = 1'b0; a_we = 4'h0;
      end else if (scramble) begin
        a_addr = $urandom; a_din = $urandom;
      end
    end
    @(negedge clk);
    chk("ready_after", {31'h0, a_ready}, 32'h0);
    chk("busy_after", {31'h0, a_busy}, 32'h0);
    chk("dout_after", a_dout, mdout);
    $display("op addr=%h din=%h re=%0d we=%b -> dout=%h", addr, din, re, we, a_dout);
  endtask

  initial begin
    logic [31:0] addr, din;
    logic        re;
    logic [3:0]  we;

    rst = 1'b1;
    a_addr = 0; a_din = 0; a_re = 0; a_we = 0;
    z_addr = 0; z_din = 0; z_re = 0; z_we = 0;
    mdout = 32'h0; mdout0 = 32'h0;
    @(negedge clk); @(negedge clk);
    chk("rst_dout", a_dout, 32'h0);
    chk("rst_ready", {31'h0, a_ready}, 32'h0);
    chk("rst_busy", {31'h0, a_busy}, 32'h0);
    chk("rst_dout0", z_dout, 32'h0);
    rst = 1'b0;

    // Word write then read
    run_op(32'h10, 32'hDEADBEEF, 1'b0, 4'hF, 1'b0);
    run_op(32'h10, 32'h0, 1'b1, 4'h0, 1'b0);
    chk("word_rd", a_dout, 32'hDEADBEEF);

    // Byte and half lanes
    run_op(32'h10, 32'h55555555, 1'b0, 4'b0100, 1'b0);
    run_op(32'h10, 32'h0, 1'b1, 4'h0, 1'b0);
    chk("byte_rd", a_dout, 32'hDE55BEEF);
    run_op(32'h10, 32'hAAAAAAAA, 1'b0, 4'b0011, 1'b0);
    run_op(32'h10, 32'h0, 1'b1, 4'h0, 1'b0);
    chk("half_rd", a_dout, 32'hDE55AAAA);

    // Simultaneous read and write is a write; DataOut holds
    run_op(32'h20, 32'h01234567, 1'b1, 4'hF, 1'b0);
    chk("rw_hold", a_dout, 32'hDE55AAAA);
    run_op(32'h20, 32'h0, 1'b1, 4'h0, 1'b0);
    chk("rw_rd", a_dout, 32'h01234567);

    // Reset mid-operation
    run_op(32'h30, 32'hCAFEF00D, 1'b0, 4'hF, 1'b0);
    @(negedge clk);
    a_addr = 32'h30; a_din = 32'h12345678; a_we = 4'hF;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_ready", {31'h0, a_ready}, 32'h0);
    chk("rst_mid_busy", {31'h0, a_busy}, 32'h0);
    chk("rst_mid_dout", a_dout, 32'h0);
    a_we = 4'h0;
    @(negedge clk);
    chk("rst_hold_ready", {31'h0, a_ready}, 32'h0);
    rst = 1'b0;
    mdout = 32'h0;
    mdout0 = 32'h0;
    @(negedge clk);
    chk("rst_post_ready", {31'h0, a_ready}, 32'h0);
    run_op(32'h30, 32'h0, 1'b1, 4'h0, 1'b0);
    chk("rst_rd", a_dout, 32'hCAFEF00D);

    // Alias and inputs toggled during WAIT
    run_op(32'h1010, 32'h0BADF00D, 1'b0, 4'hF, 1'b1);
    run_op(32'h10, 32'h0, 1'b1, 4'h0, 1'b1);
    chk("alias_rd", a_dout, 32'h0BADF00D);

    // Zero wait states: write, then read held for 4 cycles back to back
    @(negedge clk);
    z_addr = 32'h10; z_din = 32'h13579BDF; z_we = 4'hF;
    @(negedge clk);
    chk("z_wr_ready", {31'h0, z_ready}, 32'h1);
    z_we = 4'h0;
    @(negedge clk);
    chk("z_wr_idle", {31'h0, z_ready}, 32'h0);
    z_re = 1'b1; z_addr = 32'h10;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("z_ready_c%0d", c), {31'h0, z_ready}, {31'h0, (c == 1 || c == 3)});
      if (c == 1 || c == 3) chk($sformatf("z_dout_c%0d", c), z_dout, 32'h13579BDF);
      if (c == 3) z_re = 1'b0;
      $display("zero-wait cycle %0d ready=%0d dout=%h", c, z_ready, z_dout);
    end

    // Randomized traffic over 16 words, all pre-initialised through the DUT
    for (int i = 0; i < 16; i++)
      run_op(32'h100 + 32'(i * 4), $urandom, 1'b0, 4'hF, 1'b0);
    for (int i = 0; i < 40; i++) begin
      addr = 32'h100 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3))
             + (32'($urandom_range(0, 3)) << 12);
      din  = $urandom;
      re   = 1'($urandom_range(0, 1));
      we   = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
      if (!re && we == 4'h0) re = 1'b1;
      run_op(addr, din, re, we, bit'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
